// File: rtl/cfg_pkg.sv
// Shared types and constants for the CLB configuration loader.
// Frame field positions, state encoding and the serial CRC-8 step.
package cfg_pkg;

    localparam int FRAME_W     = 23;
    localparam int OUT_SEL_HI  = 22;
    localparam int OUT_SEL_LO  = 19;
    localparam int LUT_MUX_BIT = 18;
    localparam int FF_EN_HI    = 17;
    localparam int FF_EN_LO    = 16;
    localparam int LUT_HI      = 15;
    localparam int LUT_LO      = 0;
    localparam int SYNC_W      = 8;
    localparam int COUNT_W     = 8;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_COUNT,
        ST_FRAME,
        ST_WRITE,
        ST_CRC,
        ST_DONE,
        ST_ERR
    } cfg_state_e;

    // One MSB-first bit of CRC-8: feedback is the outgoing MSB xor the new bit.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 accumulator (poly 0x07, init 0x00), one bit per enabled cycle.
// Only instantiated when CFG_LOADER_CRC_EN is defined.
module cfg_crc8
    import cfg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_next(crc, din);
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// Serial bitstream loader: sync hunt, frame count, 23-bit frames written to CLB k in order.
// Optional trailing CRC-8 check is enabled with the CFG_LOADER_CRC_EN macro.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int          NUM_CLB   = 16,
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter int          IDX_W     = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 bs_valid_i,
    input  logic                 bs_data_i,
    output logic                 bs_ready_o,
    output logic [FRAME_W-1:0]   bits_o,
    output logic [NUM_CLB-1:0]   wr_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [NUM_CLB-1:0] WR_ONE = 1;
    localparam logic [COUNT_W:0]   MAX_N  = (COUNT_W+1)'(NUM_CLB);

    cfg_state_e          state;
    logic [SYNC_W-1:0]   window;
    logic [COUNT_W-1:0]  count_sh;
    logic [COUNT_W-1:0]  n_reg;
    logic [4:0]          bit_cnt;
    logic [IDX_W-1:0]    idx;
    logic [FRAME_W-2:0]  frame_sh;

    logic                accept;
    logic                start_load;
    logic [SYNC_W-1:0]   window_next;
    logic [COUNT_W-1:0]  n_next;
    logic                last_idx;

    // A bit moves when bs_valid_i and bs_ready_o are both high at the rising edge;
    // the sender must hold bs_data_i stable while bs_valid_i waits for bs_ready_o.
    assign bs_ready_o = (state == ST_SYNC) || (state == ST_COUNT) ||
                        (state == ST_FRAME) || (state == ST_CRC);
    assign busy_o     = bs_ready_o || (state == ST_WRITE);

    assign accept      = bs_valid_i && bs_ready_o;
    assign start_load  = start_i && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign window_next = {window[SYNC_W-2:0], bs_data_i};
    assign n_next      = {count_sh[COUNT_W-2:0], bs_data_i};
    assign last_idx    = (COUNT_W'(idx) == (n_reg - 8'd1));

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] crc_val;
    logic [7:0] crc_rx;

    cfg_crc8 u_crc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (start_load),
        .en    (accept && ((state == ST_COUNT) || (state == ST_FRAME))),
        .din   (bs_data_i),
        .crc   (crc_val)
    );
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            window   <= '0;
            count_sh <= '0;
            n_reg    <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            frame_sh <= '0;
            bits_o   <= '0;
            wr_en_o  <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc_rx   <= '0;
`endif
        end else begin
            wr_en_o <= '0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_load) begin
                        state   <= ST_SYNC;
                        done_o  <= 1'b0;
                        err_o   <= 1'b0;
                        idx     <= '0;
                        window  <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_SYNC: begin
                    if (accept) begin
                        window <= window_next;
                        if (window_next == SYNC_WORD) begin
                            state   <= ST_COUNT;
                            bit_cnt <= '0;
                        end
                    end
                end
                ST_COUNT: begin
                    if (accept) begin
                        count_sh <= n_next;
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(COUNT_W - 1)) begin
                            n_reg   <= n_next;
                            bit_cnt <= '0;
                            idx     <= '0;
                            if ((n_next == '0) || ({1'b0, n_next} > MAX_N)) begin
                                state <= ST_ERR;
                                err_o <= 1'b1;
                            end else begin
                                state <= ST_FRAME;
                            end
                        end
                    end
                end
                ST_FRAME: begin
                    if (accept) begin
                        frame_sh <= {frame_sh[FRAME_W-3:0], bs_data_i};
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(FRAME_W - 1)) begin
                            bits_o  <= {frame_sh, bs_data_i};
                            wr_en_o <= WR_ONE << idx;
                            bit_cnt <= '0;
                            state   <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (last_idx) begin
`ifdef CFG_LOADER_CRC_EN
                        state   <= ST_CRC;
                        bit_cnt <= '0;
`else
                        state   <= ST_DONE;
                        done_o  <= 1'b1;
`endif
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_FRAME;
                    end
                end
`ifdef CFG_LOADER_CRC_EN
                ST_CRC: begin
                    if (accept) begin
                        crc_rx  <= {crc_rx[6:0], bs_data_i};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            if ({crc_rx[6:0], bs_data_i} == crc_val) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end else begin
                                state <= ST_ERR;
                                err_o <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
